// File: rtl/axi_wr_channel_q.sv
// Queued AXI3 write channel: buffers up to DEPTH SRAM-style writes, issues each as a
// single-beat burst with independent AW/W, and retires B responses in order.
module axi_wr_channel_q #(
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = 4,
  parameter logic [3:0]  AXI_ID = 4'd1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_sram_req,
  input  logic            data_sram_wr,
  input  logic [1:0]      data_sram_size,
  input  logic [DW/8-1:0] data_sram_wstrb,
  input  logic [31:0]     data_sram_addr,
  input  logic [DW-1:0]   data_sram_wdata,
  output logic            data_sram_addr_ok,
  output logic            data_sram_data_ok,
  output logic [3:0]      awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [3:0]      wid,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [3:0]      bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  input  logic [31:0]     chk_addr,
  output logic            chk_hit,
  output logic            wr_idle,
  output logic            wr_err
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned LSB = $clog2(NB);

  logic [31:0]   mem_addr  [DEPTH];
  logic [1:0]    mem_size  [DEPTH];
  logic [NB-1:0] mem_wstrb [DEPTH];
  logic [DW-1:0] mem_wdata [DEPTH];

  logic [PW-1:0] ins_ptr_q, ins_ptr_d;
  logic [PW-1:0] aw_ptr_q, aw_ptr_d;
  logic [PW-1:0] w_ptr_q, w_ptr_d;
  logic [PW-1:0] ret_ptr_q, ret_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] aw_cnt_q, aw_cnt_d;
  logic [CW-1:0] w_cnt_q, w_cnt_d;
  logic          wr_err_q, wr_err_d;

  logic          accept;
  logic          aw_fire;
  logic          w_fire;
  logic          b_fire;
  logic          hit_raw;
  logic [PW-1:0] chk_idx;

  // Tie-off for inputs that carry no information for this block.
  logic unused_inputs;
  assign unused_inputs = ^{bid, chk_addr[LSB-1:0]};

  // Outputs are gated by reset so valids drop in the same cycle reset is asserted.
  assign bready            = ~reset;
  assign data_sram_addr_ok = ~reset & data_sram_req & data_sram_wr & (cnt_q != CW'(DEPTH));
  assign awvalid           = ~reset & (aw_cnt_q != '0);
  assign wvalid            = ~reset & (w_cnt_q != '0);
  assign data_sram_data_ok = b_fire;

  assign accept  = data_sram_addr_ok;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign b_fire  = bvalid & bready;

  assign awid    = AXI_ID;
  assign awaddr  = mem_addr[aw_ptr_q];
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, mem_size[aw_ptr_q]};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid   = AXI_ID;
  assign wdata = mem_wdata[w_ptr_q];
  assign wstrb = mem_wstrb[w_ptr_q];
  assign wlast = 1'b1;

  assign wr_idle = (cnt_q == '0);
  assign wr_err  = wr_err_q;
  assign chk_hit = ~reset & hit_raw;

  // Scan the live window [ret_ptr, ret_ptr + cnt) for a word-address match.
  always_comb begin
    hit_raw = 1'b0;
    chk_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      chk_idx = ret_ptr_q + PW'(i);
      if ((CW'(i) < cnt_q) && (mem_addr[chk_idx][31:LSB] == chk_addr[31:LSB])) begin
        hit_raw = 1'b1;
      end
    end
  end

  always_comb begin
    ins_ptr_d = accept  ? ins_ptr_q + PW'(1) : ins_ptr_q;
    aw_ptr_d  = aw_fire ? aw_ptr_q + PW'(1)  : aw_ptr_q;
    w_ptr_d   = w_fire  ? w_ptr_q + PW'(1)   : w_ptr_q;
    ret_ptr_d = b_fire  ? ret_ptr_q + PW'(1) : ret_ptr_q;
    cnt_d     = cnt_q + CW'(accept) - CW'(b_fire);
    aw_cnt_d  = aw_cnt_q + CW'(accept) - CW'(aw_fire);
    w_cnt_d   = w_cnt_q + CW'(accept) - CW'(w_fire);
    wr_err_d  = wr_err_q | (b_fire & (bresp != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ins_ptr_q <= '0;
      aw_ptr_q  <= '0;
      w_ptr_q   <= '0;
      ret_ptr_q <= '0;
      cnt_q     <= '0;
      aw_cnt_q  <= '0;
      w_cnt_q   <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      ins_ptr_q <= ins_ptr_d;
      aw_ptr_q  <= aw_ptr_d;
      w_ptr_q   <= w_ptr_d;
      ret_ptr_q <= ret_ptr_d;
      cnt_q     <= cnt_d;
      aw_cnt_q  <= aw_cnt_d;
      w_cnt_q   <= w_cnt_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Queue payload is not reset; occupancy counters alone define validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_addr[ins_ptr_q]  <= data_sram_addr;
      mem_size[ins_ptr_q]  <= data_sram_size;
      mem_wstrb[ins_ptr_q] <= data_sram_wstrb;
      mem_wdata[ins_ptr_q] <= data_sram_wdata;
    end
  end

endmodule

// File: tb/tb_axi_wr_channel_q.sv
// Directed bench for axi_wr_channel_q (DW=32, DEPTH=4) with hand-computed expectations.
module tb_axi_wr_channel_q;

  logic        clk;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  strb_in;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        addr_ok, data_ok;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] chk_addr;
  logic        chk_hit, wr_idle, wr_err;

  int n_checks = 0;
  int n_errors = 0;
  int ok_seen  = 0;
  int aw_n = 0, w_n = 0, b_n = 0;
  int base_ok;

  axi_wr_channel_q #(
    .DW    (32),
    .DEPTH (4),
    .AXI_ID(4'd1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_sram_req    (req),
    .data_sram_wr     (wr),
    .data_sram_size   (size),
    .data_sram_wstrb  (strb_in),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata_in),
    .data_sram_addr_ok(addr_ok),
    .data_sram_data_ok(data_ok),
    .awid             (awid),
    .awaddr           (awaddr),
    .awlen            (awlen),
    .awsize           (awsize),
    .awburst          (awburst),
    .awlock           (awlock),
    .awcache          (awcache),
    .awprot           (awprot),
    .awvalid          (awvalid),
    .awready          (awready),
    .wid              (wid),
    .wdata            (wdata),
    .wstrb            (wstrb),
    .wlast            (wlast),
    .wvalid           (wvalid),
    .wready           (wready),
    .bid              (bid),
    .bresp            (bresp),
    .bvalid           (bvalid),
    .bready           (bready),
    .chk_addr         (chk_addr),
    .chk_hit          (chk_hit),
    .wr_idle          (wr_idle),
    .wr_err           (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: a B may only retire a write whose AW and W both completed earlier.
  always @(posedge clk) begin
    if (reset) begin
      aw_n = 0;
      w_n  = 0;
      b_n  = 0;
    end else begin
      if (bvalid && bready) begin
        check("b_after_aw_w", {63'd0, (aw_n > b_n) && (w_n > b_n)}, 64'd1);
        b_n++;
      end
      if (awvalid && awready) aw_n++;
      if (wvalid && wready) w_n++;
      if (data_ok) ok_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b1; size = 2'd2; strb_in = 4'hF;
    addr = '0; wdata_in = '0; awready = 1'b0; wready = 1'b0;
    bid = 4'd1; bresp = 2'b00; bvalid = 1'b0; chk_addr = '0;

    // Reset state
    cyc(); #1;
    check("rst_bready", bready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_idle", wr_idle, 1);
    cyc(); reset = 1'b0; #1;
    check("post_rst_bready", bready, 1);
    check("post_rst_awvalid", awvalid, 0);
    check("post_rst_wvalid", wvalid, 0);
    check("post_rst_data_ok", data_ok, 0);
    check("post_rst_addr_ok", addr_ok, 0);
    check("post_rst_chk_hit", chk_hit, 0);
    check("post_rst_wr_err", wr_err, 0);

    // Single write, B at N+3
    base_ok = ok_seen;
    cyc(); req = 1'b1; addr = 32'h1000_0004; wdata_in = 32'hDEAD_BEEF; #1;
    check("s_addr_ok", addr_ok, 1);
    check("s_aw_latency", awvalid, 0);
    cyc(); req = 1'b0; awready = 1'b1; wready = 1'b1; #1;
    check("s_awvalid", awvalid, 1);
    check("s_awaddr", awaddr, 32'h1000_0004);
    check("s_awsize", awsize, 3'd2);
    check("s_awlen", awlen, 8'd0);
    check("s_awburst", awburst, 2'b01);
    check("s_awid", awid, 4'd1);
    check("s_wvalid", wvalid, 1);
    check("s_wdata", wdata, 32'hDEAD_BEEF);
    check("s_wstrb", wstrb, 4'hF);
    check("s_wlast", wlast, 1);
    check("s_wid", wid, 4'd1);
    cyc(); awready = 1'b0; wready = 1'b0; #1;
    check("s_aw_done", awvalid, 0);
    check("s_w_done", wvalid, 0);
    check("s_no_early_ok", data_ok, 0);
    check("s_busy", wr_idle, 0);
    cyc(); bvalid = 1'b1; #1;
    check("s_data_ok", data_ok, 1);
    cyc(); bvalid = 1'b0; #1;
    check("s_data_ok_off", data_ok, 0);
    check("s_idle", wr_idle, 1);
    check("s_ok_count", ok_seen - base_ok, 1);

    // Fill to DEPTH, then drain
    base_ok = ok_seen;
    for (int i = 0; i < 5; i++) begin
      cyc(); req = 1'b1; addr = 32'h100 + 32'(4 * i); wdata_in = 32'(i); #1;
      check("f_addr_ok", addr_ok, (i < 4) ? 64'd1 : 64'd0);
    end
    cyc(); awready = 1'b1; wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      #1;
      check("f_awaddr", awaddr, 32'h100 + 32'(4 * k));
      check("f_full", addr_ok, 0);
    end
    cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; #1;
    check("f_ok0", data_ok, 1);
    check("f_full_despite_b", addr_ok, 0);
    check("f_aw_empty", awvalid, 0);
    cyc(); #1;
    check("f_fifth_accepted", addr_ok, 1);
    check("f_ok1", data_ok, 1);
    cyc(); req = 1'b0; #1;
    check("f_ok2", data_ok, 1);
    check("f_fifth_awaddr", awaddr, 32'h110);
    cyc(); #1;
    check("f_ok3", data_ok, 1);
    cyc(); bvalid = 1'b0; awready = 1'b1; wready = 1'b1; #1;
    check("f_fifth_awvalid", awvalid, 1);
    check("f_fifth_wdata", wdata, 32'd4);
    cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; #1;
    check("f_ok4", data_ok, 1);
    cyc(); bvalid = 1'b0; #1;
    check("f_idle", wr_idle, 1);
    check("f_ok_count", ok_seen - base_ok, 5);

    // W ahead of AW
    cyc(); req = 1'b1; addr = 32'h200; wdata_in = 32'h11; wready = 1'b1; #1;
    check("k_addr_ok", addr_ok, 1);
    cyc(); addr = 32'h204; wdata_in = 32'h22; #1;
    check("k_wvalid", wvalid, 1);
    check("k_wdata0", wdata, 32'h11);
    check("k_awaddr_stall0", awaddr, 32'h200);
    cyc(); addr = 32'h208; wdata_in = 32'h33; #1;
    check("k_wdata1", wdata, 32'h22);
    check("k_awaddr_stall1", awaddr, 32'h200);
    cyc(); req = 1'b0; #1;
    check("k_wdata2", wdata, 32'h33);
    check("k_awaddr_stall2", awaddr, 32'h200);
    check("k_awvalid_stall", awvalid, 1);
    cyc(); awready = 1'b1; #1;
    check("k_w_drained", wvalid, 0);
    check("k_awaddr0", awaddr, 32'h200);
    cyc(); #1;
    check("k_awaddr1", awaddr, 32'h204);
    cyc(); #1;
    check("k_awaddr2", awaddr, 32'h208);
    cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; #1;
    check("k_aw_drained", awvalid, 0);
    check("k_ok", data_ok, 1);
    cyc(); #1;
    cyc(); #1;
    cyc(); bvalid = 1'b0; #1;
    check("k_idle", wr_idle, 1);

    // Hazard check on a byte store
    cyc(); req = 1'b1; addr = 32'h2000_0008; size = 2'd0; strb_in = 4'h1;
    wdata_in = 32'hAB; chk_addr = 32'h2000_0008; #1;
    check("h_addr_ok", addr_ok, 1);
    check("h_same_cycle_excluded", chk_hit, 0);
    cyc(); req = 1'b0; size = 2'd2; strb_in = 4'hF; chk_addr = 32'h2000_000B; #1;
    check("h_hit_same_word", chk_hit, 1);
    chk_addr = 32'h2000_000C; #1;
    check("h_miss_next_word", chk_hit, 0);
    chk_addr = 32'h2000_0004; #1;
    check("h_miss_prev_word", chk_hit, 0);
    cyc(); awready = 1'b1; wready = 1'b1; chk_addr = 32'h2000_000B; #1;
    check("h_awsize", awsize, 3'd0);
    check("h_wstrb", wstrb, 4'h1);
    check("h_hit_issued", chk_hit, 1);
    cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; #1;
    check("h_ok", data_ok, 1);
    check("h_hit_until_retire", chk_hit, 1);
    cyc(); bvalid = 1'b0; #1;
    check("h_hit_cleared", chk_hit, 0);
    check("h_idle", wr_idle, 1);

    // Streaming with wrap and an error response on the 7th B
    base_ok = ok_seen;
    awready = 1'b1; wready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      cyc();
      req = (c < 10);
      addr = 32'h3000_0000 + 32'(4 * c);
      wdata_in = 32'(c);
      bvalid = (c >= 2) && (c < 12);
      bresp = (c == 8) ? 2'b10 : 2'b00;
      #1;
      if (c < 10) check("e_addr_ok", addr_ok, 1);
      if (c >= 1 && c <= 10) check("e_awaddr", awaddr, 32'h3000_0000 + 32'(4 * (c - 1)));
      if (c >= 1 && c <= 10) check("e_wdata", wdata, 32'(c - 1));
      if (bvalid) check("e_data_ok", data_ok, 1);
      if (c == 8) check("e_err_not_yet", wr_err, 0);
      if (c == 9) check("e_err_set", wr_err, 1);
    end
    cyc(); bvalid = 1'b0; bresp = 2'b00; awready = 1'b0; wready = 1'b0; #1;
    check("e_idle", wr_idle, 1);
    check("e_ok_count", ok_seen - base_ok, 10);
    cyc(); #1;
    cyc(); #1;
    check("e_err_sticky", wr_err, 1);

    // Reset with writes in flight
    for (int i = 0; i < 3; i++) begin
      cyc(); req = 1'b1; addr = 32'h400 + 32'(4 * i); #1;
      check("r_addr_ok", addr_ok, 1);
    end
    cyc(); req = 1'b0; #1;
    check("r_awvalid_pending", awvalid, 1);
    check("r_busy", wr_idle, 0);
    cyc(); reset = 1'b1; #1;
    check("r_awvalid_dropped", awvalid, 0);
    check("r_bready_low", bready, 0);
    cyc(); reset = 1'b0; #1;
    check("r_awvalid", awvalid, 0);
    check("r_wvalid", wvalid, 0);
    check("r_idle", wr_idle, 1);
    check("r_err_cleared", wr_err, 0);
    check("r_bready", bready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
